// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
//   fetch_state_t : fetch sequencer states
//   fetch_entry_t : one prefetched instruction plus the address it came from
package fetch_pkg;

    localparam logic [31:0] ROM_BASE_DEFAULT   = 32'h0000_1000;
    localparam int          ROM_BYTES_DEFAULT  = 4096;
    localparam int          FIFO_DEPTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch FIFO holding assembled instructions for the CPU front end.
// Ports:
//   clk, rst   : clock, async active-high reset (empties the FIFO)
//   push       : write push_data; honoured when not full or when popping
//   push_data  : entry to store
//   pop        : drop the head entry; ignored while empty
//   flush      : discard all entries; wins over push and pop
//   full/empty : occupancy flags
//   head       : oldest entry (content undefined while empty)
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    fetch_entry_t  mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one the pop frees this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: reads the byte-wide instruction ROM one byte
// per cycle, assembles 4-byte instructions MSB-first, queues them in a
// prefetch FIFO and handles PC redirects and out-of-window fetch faults.
// Ports:
//   clk, rst        : clock, async active-high reset
//   mem_en          : ROM byte read strobe
//   mem_addr        : ROM byte address
//   mem_rdata       : ROM byte, combinational from mem_addr
//   instr_valid     : FIFO head holds an instruction
//   instr, instr_pc : head instruction and its address (zero while empty)
//   instr_ready     : consumer takes the head this cycle
//   redirect_valid  : flush and restart fetch at redirect_pc
//   redirect_pc     : new fetch PC
//   fault           : fetch stopped on a misaligned or out-of-window PC
//
// state | meaning
// FETCH | reading byte byte_cnt of the word at fetch_pc
// STALL | word complete except last byte, FIFO full; re-reading byte 3
// FAULT | fetch_pc failed the window check; waiting for a redirect
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] ROM_BASE   = ROM_BASE_DEFAULT,
    parameter int          ROM_BYTES  = ROM_BYTES_DEFAULT,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    // One past the last ROM byte; 33 bits so a window ending at 4 GiB works.
    localparam logic [32:0] ROM_END = {1'b0, ROM_BASE} + 33'(ROM_BYTES);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  fetch_pc;
    logic [1:0]   byte_cnt;
    logic [23:0]  lanes;
    logic [32:0]  last_byte;
    logic         pc_legal;
    logic         capture;
    logic         push;
    logic         pop;
    logic         can_accept;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t push_data;
    fetch_entry_t head;

    assign last_byte  = {1'b0, fetch_pc} + 33'd3;
    assign pc_legal   = (fetch_pc[1:0] == 2'b00) && (fetch_pc >= ROM_BASE) &&
                        (last_byte < ROM_END);
    assign pop        = instr_valid && instr_ready;
    assign can_accept = !fifo_full || pop;
    // The last byte is taken straight from the ROM, never registered.
    assign push_data  = {{lanes, mem_rdata}, fetch_pc};
    assign mem_addr   = fetch_pc + {30'd0, byte_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        capture    = 1'b0;
        push       = 1'b0;
        case (state)
            FETCH: begin
                if (byte_cnt == 2'd0 && !pc_legal) begin
                    state_next = FAULT;
                end else begin
                    mem_en  = 1'b1;
                    capture = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        if (can_accept) push = 1'b1;
                        else            state_next = STALL;
                    end
                end
            end
            STALL: begin
                mem_en = 1'b1;
                if (can_accept) begin
                    push       = 1'b1;
                    state_next = FETCH;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
        // Redirect kills whatever word is in flight, including a push.
        if (redirect_valid) begin
            state_next = FETCH;
            capture    = 1'b0;
            push       = 1'b0;
        end
        if (rst) mem_en = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= ROM_BASE;
            byte_cnt <= 2'd0;
            lanes    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            byte_cnt <= 2'd0;
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
            byte_cnt <= 2'd0;
        end else if (capture && byte_cnt != 2'd3) begin
            case (byte_cnt)
                2'd0:    lanes[23:16] <= mem_rdata;
                2'd1:    lanes[15:8]  <= mem_rdata;
                default: lanes[7:0]   <= mem_rdata;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    prefetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = instr_valid ? head.instr : 32'd0;
    assign instr_pc    = instr_valid ? head.pc    : 32'd0;
    assign fault       = (state == FAULT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_instr_fetch_ctrl;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          BYTES = 4096;
    localparam longint      END_A = 64'h0000_2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(
        .ROM_BASE   (BASE),
        .ROM_BYTES  (BYTES),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault)
    );

    // ROM model
    logic [7:0]  rom [BYTES];
    logic [31:0] rom_off;
    assign rom_off   = mem_addr - BASE;
    assign mem_rdata = (mem_addr >= BASE && mem_addr < BASE + BYTES) ? rom[rom_off[11:0]] : 8'h00;

    int errors = 0;
    int checks = 0;

    // Reference model: after a (re)start at a legal PC the core must deliver
    // consecutive words in address order until the end of the ROM window.
    logic [63:0] exp_q [$];
    longint      exp_next;
    bit          exp_live;

    function automatic logic [31:0] word_at(longint pc);
        int off;
        off = int'(pc - BASE);
        return {rom[off], rom[off + 1], rom[off + 2], rom[off + 3]};
    endfunction

    function automatic bit in_window(logic [31:0] a);
        return ({32'd0, a} >= longint'(BASE)) && ({32'd0, a} < END_A);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic topup();
        while (exp_live && exp_q.size() < 8 && exp_next + 4 <= END_A) begin
            exp_q.push_back({word_at(exp_next), exp_next[31:0]});
            exp_next += 4;
        end
    endtask

    task automatic restart_model(logic [31:0] pc);
        exp_q.delete();
        exp_next = {32'd0, pc};
        exp_live = (pc[1:0] == 2'b00) && ({32'd0, pc} >= longint'(BASE)) &&
                   ({32'd0, pc} + 3 < END_A);
        topup();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        topup();
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_mem_en"},      mem_en,      1'b0);
        check({tag, "_mem_addr"},    mem_addr,    BASE);
        check({tag, "_instr_valid"}, instr_valid, 1'b0);
        check({tag, "_instr"},       instr,       32'd0);
        check({tag, "_instr_pc"},    instr_pc,    32'd0);
        check({tag, "_fault"},       fault,       1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        restart_model(BASE);
        #1;
        check_reset_outputs("async_rst");
        step();
        rst = 1'b0;
    endtask

    task automatic do_redirect(logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        restart_model(pc);
        step();
        redirect_valid = 1'b0;
    endtask

    // Monitor: compares every accepted head against the model and checks
    // head stability and that reads stay inside the ROM window.
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    bit          hold_pending = 1'b0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (mem_en) check("fetch_in_window", {63'd0, in_window(mem_addr)}, 64'd1);
            if (hold_pending && instr_valid) begin
                check("hold_instr", instr, held_instr);
                check("hold_pc", instr_pc, held_pc);
            end
            hold_pending = instr_valid && !instr_ready && !redirect_valid;
            held_instr   = instr;
            held_pc      = instr_pc;
            if (instr_valid && instr_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h instr %h, expected no delivery",
                             instr_pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_data", instr, e[63:32]);
                    check("instr_pc", instr_pc, e[31:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pc;
        for (int i = 0; i < BYTES; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h13; rom[1] = 8'h05; rom[2] = 8'h00; rom[3] = 8'h00;
        rom[4] = 8'h93; rom[5] = 8'h05; rom[6] = 8'h10; rom[7] = 8'h00;

        rst            = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        restart_model(BASE);
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;

        // First two words, consumer always ready
        repeat (3) step();
        check("first_not_yet_valid", instr_valid, 1'b0);
        step();
        check("first_valid", instr_valid, 1'b1);
        check("first_instr", instr, 32'h1305_0000);
        check("first_pc", instr_pc, 32'h0000_1000);
        repeat (3) step();
        check("second_not_yet_valid", instr_valid, 1'b0);
        step();
        check("second_valid", instr_valid, 1'b1);
        check("second_instr", instr, 32'h9305_1000);
        check("second_pc", instr_pc, 32'h0000_1004);

        // Back-pressure: FIFO fills, third word stalls on its last byte
        instr_ready = 1'b0;
        do_reset();
        repeat (20) step();
        check("stall_valid", instr_valid, 1'b1);
        check("stall_head_pc", instr_pc, 32'h0000_1000);
        check("stall_mem_en", mem_en, 1'b1);
        check("stall_mem_addr", mem_addr, 32'h0000_100B);
        instr_ready = 1'b1;
        step();
        check("drain1_pc", instr_pc, 32'h0000_1004);
        step();
        check("drain2_pc", instr_pc, 32'h0000_1008);
        check("drain2_valid", instr_valid, 1'b1);
        step();
        check("drain3_empty", instr_valid, 1'b0);

        // Redirect mid-word with one entry queued
        instr_ready = 1'b0;
        do_reset();
        repeat (6) step();
        check("pre_redirect_valid", instr_valid, 1'b1);
        do_redirect(32'h0000_1100);
        instr_ready = 1'b1;
        check("redirect_flush", instr_valid, 1'b0);
        check("redirect_mem_addr", mem_addr, 32'h0000_1100);
        repeat (3) step();
        check("redirect_not_yet_valid", instr_valid, 1'b0);
        step();
        check("redirect_valid_out", instr_valid, 1'b1);
        check("redirect_pc_out", instr_pc, 32'h0000_1100);

        // Misaligned target faults, legal target recovers
        do_redirect(32'h0000_1002);
        check("misalign_fault_early", fault, 1'b0);
        check("misalign_mem_en_early", mem_en, 1'b0);
        step();
        check("misalign_fault", fault, 1'b1);
        check("misalign_mem_en", mem_en, 1'b0);
        repeat (3) step();
        check("fault_held", fault, 1'b1);
        do_redirect(32'h0000_1000);
        check("recover_fault", fault, 1'b0);
        check("recover_mem_en", mem_en, 1'b1);
        check("recover_mem_addr", mem_addr, 32'h0000_1000);

        // Last word of the window, then fault with no wrap
        do_redirect(32'h0000_1FFC);
        repeat (3) step();
        step();
        check("last_word_valid", instr_valid, 1'b1);
        check("last_word_pc", instr_pc, 32'h0000_1FFC);
        check("end_mem_en", mem_en, 1'b0);
        step();
        check("end_fault", fault, 1'b1);
        check("end_mem_en_fault", mem_en, 1'b0);
        check("end_drained", instr_valid, 1'b0);

        // Reset while stalled with a full FIFO
        instr_ready = 1'b0;
        do_redirect(32'h0000_1000);
        repeat (14) step();
        check("full_valid", instr_valid, 1'b1);
        check("full_stall_addr", mem_addr, 32'h0000_100B);
        instr_ready = 1'b1;
        do_reset();
        repeat (4) step();
        check("post_rst_valid", instr_valid, 1'b1);
        check("post_rst_pc", instr_pc, 32'h0000_1000);

        // Randomized traffic with occasional redirects
        for (int n = 0; n < 3000; n++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 9))
                    0:       pc = BASE + 4 * $urandom_range(0, 1023) + $urandom_range(1, 3);
                    1:       pc = $urandom_range(0, 32'h0FFF) & ~32'd3;
                    2:       pc = BASE + BYTES + 4 * $urandom_range(0, 255);
                    3:       pc = BASE + BYTES - 4 * $urandom_range(1, 3);
                    default: pc = BASE + 4 * $urandom_range(0, 1023);
                endcase
                redirect_valid = 1'b1;
                redirect_pc    = pc;
                restart_model(pc);
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
